read_bpm_test_link: RTL and testbench

- Receive-side checker for the BPM test-pattern AXI stream produced by the BPM test-link writer over Aurora.
- Consumes 4-word packets (header, X, Y, sum) and verifies every field against the expected pattern for the current fast-acquisition (FA) session.
- Reports per-packet status and keeps error/packet/session counters for link bring-up and soak testing.
- Sits in the Aurora user clock domain, directly on the Aurora RX user interface.

---
 rtl/read_bpm_test_link_if.sv | 20 ++
 rtl/read_bpm_test_link.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_read_bpm_test_link.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/read_bpm_test_link_if.sv
// ---------------------------------------------------------------------------
// read_bpm_test_link_if
// AXI-stream bundle that carries the BPM test pattern from the Aurora RX user
// interface into the test-link checker.
//   tdata  : 32-bit stream word
//   tvalid : word present
//   tlast  : final word of a packet
//   tready : sink ready (driven by the checker)
// master : the stream source (Aurora core or a testbench driver)
// slave  : the checker
// ---------------------------------------------------------------------------
interface read_bpm_test_link_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/read_bpm_test_link.sv
// ---------------------------------------------------------------------------
// read_bpm_test_link
// Receive-side checker for the BPM test-pattern stream sent over Aurora.
// Each packet is four words (header, X, Y, sum). Every field is compared with
// the pattern expected for the current fast-acquisition (FA) session and a
// one-cycle status pulse is issued per packet verdict or session-level error.
//
// Ports
//   auroraUserClk          : clock (Aurora user clock)
//   auroraResetN           : asynchronous active-low reset
//   auroraFAstrobe         : single-cycle start of a new FA session
//   auroraChannelUp        : Aurora channel status; low drops all traffic
//   clearCounters          : synchronous clear of all counters
//   BPM_TEST_AXI_STREAM_RX : stream input (slave modport), tready always 1
//   TESTstatusStrobe       : one-cycle verdict pulse
//   TESTstatusCode         : 0 ok, 1 header, 2 payload, 3 framing/sequence
//   packetCount            : good packets (saturating)
//   errorCount             : non-zero verdicts (saturating)
//   sessionCount           : error-free complete sessions (saturating)
//   dbgRxState             : current receive state
// ---------------------------------------------------------------------------
module read_bpm_test_link #(
  parameter int    BPM_GLOBAL_INDEX     = 2,
  parameter int    BPM_COUNT_PER_SECTOR = 16,
  parameter int    CELL_INDEX           = 12,
  parameter string stateDebug           = "false"
) (
  input  logic                        auroraUserClk,
  input  logic                        auroraResetN,
  input  logic                        auroraFAstrobe,
  input  logic                        auroraChannelUp,
  input  logic                        clearCounters,
  read_bpm_test_link_if.slave         BPM_TEST_AXI_STREAM_RX,
  output logic                        TESTstatusStrobe,
  output logic [1:0]                  TESTstatusCode,
  output logic [31:0]                 packetCount,
  output logic [15:0]                 errorCount,
  output logic [15:0]                 sessionCount,
  output logic [2:0]                  dbgRxState
);

  typedef enum logic [2:0] {
    RX_HEADER  = 3'd0,
    RX_X       = 3'd1,
    RX_Y       = 3'd2,
    RX_SUM     = 3'd3,
    RX_DISCARD = 3'd4
  } rxState_t;

  localparam logic [5:0]  COUNT     = 6'(BPM_COUNT_PER_SECTOR);
  // Header bits [31:5]: marker, cell index, reserved zero, FOFB prefix.
  localparam logic [26:0] HDR_FIXED = {16'hA5BE, 1'b1, 5'(CELL_INDEX), 1'b0,
                                       4'(BPM_GLOBAL_INDEX)};

  localparam logic [1:0] CODE_OK    = 2'd0;
  localparam logic [1:0] CODE_HDR   = 2'd1;
  localparam logic [1:0] CODE_PAY   = 2'd2;
  localparam logic [1:0] CODE_FRAME = 2'd3;

  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Registered state
  rxState_t    rxState, rxNext;
  logic        readyReg;
  logic [5:0]  expIdx;
  logic        sessErr;
  logic        sessSet;
  logic [14:0] cycleValue;
  logic        cycleValid;
  logic [1:0]  pendCode;
  logic        resyncValid;
  logic [5:0]  resyncIdx;

  // Decode of the current word
  logic [31:0] tdata;
  logic        tlast;
  logic        wordAccept;
  logic        chanUp;
  rxState_t    effState;
  logic [5:0]  effIdx;
  logic        effSessErr;
  logic        effSessSet;
  logic        hdrUpperOk;
  logic [5:0]  hdrRxIdx;
  logic        hdrOk;
  logic        resyncNow;
  logic        xOk;
  logic        yOk;
  logic [14:0] faVal;
  logic [14:0] faExpect;
  logic        faOk;
  logic        sumOk;

  // Verdict decode
  logic        wordErr;
  logic [1:0]  wordCode;
  logic        enterDiscard;
  logic        verdictVld;
  logic        verdictBad;
  logic [1:0]  verdictCode;
  logic        strobeIncomplete;
  logic        statusVld;
  logic [1:0]  statusCode;
  logic        resyncUse;
  logic [5:0]  resyncIdxUse;
  logic [5:0]  nextIdx;
  logic        sessDone;
  logic        sumSeen;

  assign tdata      = BPM_TEST_AXI_STREAM_RX.tdata;
  assign tlast      = BPM_TEST_AXI_STREAM_RX.tlast;
  assign wordAccept = BPM_TEST_AXI_STREAM_RX.tvalid && readyReg;
  assign chanUp     = auroraChannelUp;
  assign BPM_TEST_AXI_STREAM_RX.tready = readyReg;
  assign dbgRxState = rxState;

  // A strobe coinciding with a word makes that word the first header of the
  // new session, so all checks use the post-strobe view of the session.
  assign effState   = auroraFAstrobe ? RX_HEADER : rxState;
  assign effIdx     = auroraFAstrobe ? 6'd0 : expIdx;
  assign effSessErr = auroraFAstrobe ? 1'b0 : sessErr;
  assign effSessSet = auroraFAstrobe ? 1'b0 : sessSet;

  assign hdrUpperOk = (tdata[31:5] == HDR_FIXED);
  assign hdrRxIdx   = {1'b0, tdata[4:0]};
  // Once the session is complete no header index is acceptable.
  assign hdrOk      = (effIdx < COUNT) && hdrUpperOk && (tdata[4:0] == effIdx[4:0]);
  assign resyncNow  = hdrUpperOk && (tdata[4:0] != effIdx[4:0]) && (hdrRxIdx < COUNT);
  assign xOk        = (tdata == {16'hCAFE, 11'd0, effIdx[4:0]});
  assign yOk        = (tdata == {16'hBEEF, 11'd0, effIdx[4:0]});

  // First sum of a session must advance the previous session value by one,
  // unless no previous value exists (after reset or a channel drop).
  assign faVal      = tdata[30:16];
  assign faExpect   = effSessSet ? cycleValue : cycleValue + 15'd1;
  assign faOk       = (!effSessSet && !cycleValid) || (faVal == faExpect);
  assign sumOk      = !tdata[31] && (tdata[15:0] == {10'd0, effIdx}) && faOk;

  // State register (optionally tagged for on-chip debug capture)
  generate
    if (stateDebug == "true") begin : gStateDbg
      (* mark_debug = "true" *) rxState_t stateQ;
      always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
        if (!auroraResetN) stateQ <= RX_HEADER;
        else               stateQ <= rxNext;
      end
      assign rxState = stateQ;
    end else begin : gStatePlain
      rxState_t stateQ;
      always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
        if (!auroraResetN) stateQ <= RX_HEADER;
        else               stateQ <= rxNext;
      end
      assign rxState = stateQ;
    end
  endgenerate

  // Next-state logic
  always_comb begin
    rxNext = rxState;
    if (!chanUp) begin
      rxNext = RX_HEADER;
    end else begin
      if (auroraFAstrobe) rxNext = RX_HEADER;
      if (wordAccept) begin
        case (effState)
          RX_HEADER:  rxNext = tlast ? RX_HEADER : (hdrOk ? RX_X   : RX_DISCARD);
          RX_X:       rxNext = tlast ? RX_HEADER : (xOk   ? RX_Y   : RX_DISCARD);
          RX_Y:       rxNext = tlast ? RX_HEADER : (yOk   ? RX_SUM : RX_DISCARD);
          RX_SUM:     rxNext = tlast ? RX_HEADER : RX_DISCARD;
          RX_DISCARD: rxNext = tlast ? RX_HEADER : RX_DISCARD;
          default:    rxNext = RX_HEADER;
        endcase
      end
    end
  end

  // Output / verdict decode
  always_comb begin
    wordErr  = 1'b0;
    wordCode = CODE_OK;
    case (effState)
      RX_HEADER: begin
        if (tlast)       begin wordErr = 1'b1; wordCode = CODE_FRAME; end
        else if (!hdrOk) begin wordErr = 1'b1; wordCode = CODE_HDR;   end
      end
      RX_X: begin
        if (tlast)     begin wordErr = 1'b1; wordCode = CODE_FRAME; end
        else if (!xOk) begin wordErr = 1'b1; wordCode = CODE_PAY;   end
      end
      RX_Y: begin
        if (tlast)     begin wordErr = 1'b1; wordCode = CODE_FRAME; end
        else if (!yOk) begin wordErr = 1'b1; wordCode = CODE_PAY;   end
      end
      RX_SUM: begin
        if (!tlast)      begin wordErr = 1'b1; wordCode = CODE_FRAME; end
        else if (!sumOk) begin wordErr = 1'b1; wordCode = CODE_PAY;   end
      end
      default: begin
        wordErr  = 1'b0;
        wordCode = CODE_OK;
      end
    endcase

    enterDiscard = chanUp && wordAccept && (rxNext == RX_DISCARD) &&
                   (effState != RX_DISCARD);
    sumSeen      = chanUp && wordAccept && (effState == RX_SUM) && tlast;

    verdictVld   = chanUp && wordAccept && tlast;
    if (effState == RX_DISCARD) verdictCode = pendCode;
    else if (wordErr)           verdictCode = wordCode;
    else                        verdictCode = CODE_OK;
    verdictBad   = (verdictCode != CODE_OK);

    // Resynchronise to the received index only when the header was intact
    // apart from its index field.
    resyncUse    = (effState == RX_HEADER) ? resyncNow : resyncValid;
    resyncIdxUse = (effState == RX_HEADER) ? hdrRxIdx  : resyncIdx;
    if (effIdx >= COUNT)  nextIdx = effIdx;
    else if (!verdictBad) nextIdx = effIdx + 6'd1;
    else if (resyncUse)   nextIdx = resyncIdxUse + 6'd1;
    else                  nextIdx = effIdx + 6'd1;

    sessDone = verdictVld && !verdictBad && (nextIdx == COUNT) && !effSessErr;

    strobeIncomplete = chanUp && auroraFAstrobe && (expIdx != 6'd0) && (expIdx < COUNT);
    statusVld  = strobeIncomplete || verdictVld;
    statusCode = strobeIncomplete ? CODE_FRAME : verdictCode;
  end

  // Session / datapath registers
  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      readyReg         <= 1'b0;
      TESTstatusStrobe <= 1'b0;
      TESTstatusCode   <= CODE_OK;
      expIdx           <= 6'd0;
      sessErr          <= 1'b0;
      sessSet          <= 1'b0;
      cycleValue       <= 15'd0;
      cycleValid       <= 1'b0;
      pendCode         <= CODE_OK;
      resyncValid      <= 1'b0;
      resyncIdx        <= 6'd0;
    end else begin
      readyReg         <= 1'b1;
      TESTstatusStrobe <= statusVld;
      TESTstatusCode   <= statusVld ? statusCode : CODE_OK;
      if (!chanUp) begin
        expIdx      <= 6'd0;
        sessErr     <= 1'b0;
        sessSet     <= 1'b0;
        cycleValid  <= 1'b0;
        pendCode    <= CODE_OK;
        resyncValid <= 1'b0;
      end else begin
        if (auroraFAstrobe) begin
          expIdx  <= 6'd0;
          sessErr <= 1'b0;
          sessSet <= 1'b0;
        end
        if (wordAccept && (effState == RX_HEADER)) begin
          resyncValid <= resyncNow;
          resyncIdx   <= hdrRxIdx;
        end
        if (enterDiscard) pendCode <= wordCode;
        if (verdictVld) begin
          expIdx <= nextIdx;
          if (verdictBad) sessErr <= 1'b1;
        end
        // The first checked sum fixes the session value, even when it failed
        // the increment check, so the rest of the session is judged on it.
        if (sumSeen && !effSessSet) begin
          cycleValue <= faVal;
          cycleValid <= 1'b1;
          sessSet    <= 1'b1;
        end
      end
    end
  end

  // Counters
  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      packetCount  <= 32'd0;
      errorCount   <= 16'd0;
      sessionCount <= 16'd0;
    end else if (clearCounters) begin
      packetCount  <= 32'd0;
      errorCount   <= 16'd0;
      sessionCount <= 16'd0;
    end else begin
      if (verdictVld && !verdictBad)              packetCount  <= satInc32(packetCount);
      if (statusVld && (statusCode != CODE_OK))   errorCount   <= satInc16(errorCount);
      if (sessDone)                               sessionCount <= satInc16(sessionCount);
    end
  end

endmodule

// File: tb/tb_read_bpm_test_link.sv
// ---------------------------------------------------------------------------
// tb_read_bpm_test_link
// Directed bench for read_bpm_test_link with the default parameters
// (prefix 2, 16 packets per session, cell 12). Status pulses are collected
// into a queue and compared against hand-computed verdict sequences.
// ---------------------------------------------------------------------------
module tb_read_bpm_test_link;

  logic        clk = 1'b0;
  logic        rstN;
  logic        faStrobe;
  logic        chanUp;
  logic        clearCnt;
  logic        statusStrobe;
  logic [1:0]  statusCode;
  logic [31:0] packetCount;
  logic [15:0] errorCount;
  logic [15:0] sessionCount;
  logic [2:0]  dbgRxState;

  int nCompared = 0;
  int nMismatch = 0;
  logic [1:0] codeQ[$];

  read_bpm_test_link_if rxIf ();

  read_bpm_test_link dut (
    .auroraUserClk          (clk),
    .auroraResetN           (rstN),
    .auroraFAstrobe         (faStrobe),
    .auroraChannelUp        (chanUp),
    .clearCounters          (clearCnt),
    .BPM_TEST_AXI_STREAM_RX (rxIf),
    .TESTstatusStrobe       (statusStrobe),
    .TESTstatusCode         (statusCode),
    .packetCount            (packetCount),
    .errorCount             (errorCount),
    .sessionCount           (sessionCount),
    .dbgRxState             (dbgRxState)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (statusStrobe) codeQ.push_back(statusCode);

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Expect n verdicts, all 0 except badCode at position badPos (-1: none).
  task automatic checkCodes(input string tag, input int n, input int badPos, input logic [1:0] badCode);
    checkVal({tag, ".n"}, 32'(codeQ.size()), 32'(n));
    for (int k = 0; k < n && k < codeQ.size(); k++)
      checkVal($sformatf("%s.code%0d", tag, k), 32'(codeQ[k]),
               (k == badPos) ? 32'(badCode) : 32'd0);
    codeQ.delete();
  endtask

  task automatic checkCounts(input string tag, input int pk, input int er, input int se);
    checkVal({tag, ".packetCount"},  packetCount,         32'(pk));
    checkVal({tag, ".errorCount"},   32'(errorCount),     32'(er));
    checkVal({tag, ".sessionCount"}, 32'(sessionCount),   32'(se));
  endtask

  function automatic logic [31:0] hdrWord(input int i);
    return 32'hA5BE_B040 | 32'(i);
  endfunction

  function automatic logic [31:0] sumWord(input int i, input int fa);
    logic [14:0] f;
    f = 15'(fa);
    return {1'b0, f, 16'(i)};
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rxIf.tvalid = 1'b0;
      rxIf.tlast  = 1'b0;
    end
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last, input bit gap);
    @(negedge clk);
    rxIf.tdata  = d;
    rxIf.tvalid = 1'b1;
    rxIf.tlast  = last;
    if (gap) idle(1);
  endtask

  task automatic sendPkt(input int i, input int fa, input bit gap);
    sendWord(hdrWord(i), 1'b0, gap);
    sendWord(32'hCAFE_0000 | 32'(i), 1'b0, gap);
    sendWord(32'hBEEF_0000 | 32'(i), 1'b0, gap);
    sendWord(sumWord(i, fa), 1'b1, gap);
  endtask

  task automatic strobe();
    @(negedge clk);
    rxIf.tvalid = 1'b0;
    rxIf.tlast  = 1'b0;
    faStrobe    = 1'b1;
    @(negedge clk);
    faStrobe    = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; faStrobe = 1'b0; chanUp = 1'b1; clearCnt = 1'b0;
    rxIf.tdata = 32'd0; rxIf.tvalid = 1'b0; rxIf.tlast = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("rst.tready", 32'(rxIf.tready), 32'd0);
    checkVal("rst.strobe", 32'(statusStrobe), 32'd0);
    checkVal("rst.state",  32'(dbgRxState),   32'd0);
    checkCounts("rst", 0, 0, 0);
    rstN = 1'b1;
    idle(2);
    checkVal("rel.tready", 32'(rxIf.tready), 32'd1);

    // Session 1: clean, FA value 7 (exempt from increment check)
    strobe();
    for (int i = 0; i < 16; i++) sendPkt(i, 7, 1'b0);
    idle(3);
    checkCodes("s1", 16, -1, 2'd0);
    checkCounts("s1", 16, 0, 1);

    // Session 2: FA value 9 instead of 8 -> payload error on packet 0
    strobe();
    for (int i = 0; i < 16; i++) sendPkt(i, 9, 1'b0);
    idle(3);
    checkCodes("s2", 16, 0, 2'd2);
    checkCounts("s2", 31, 1, 1);

    // Session 3: header carries index 5 where 4 expected -> resync to 6
    strobe();
    for (int i = 0; i < 4; i++) sendPkt(i, 10, 1'b0);
    sendPkt(5, 10, 1'b0);
    for (int i = 6; i < 16; i++) sendPkt(i, 10, 1'b0);
    idle(3);
    checkCodes("s3", 15, 4, 2'd1);
    checkCounts("s3", 45, 2, 1);

    // Session 4: tlast on the Y word -> framing error, no discard
    strobe();
    sendPkt(0, 11, 1'b0);
    sendWord(hdrWord(1), 1'b0, 1'b0);
    sendWord(32'hCAFE_0001, 1'b0, 1'b0);
    sendWord(32'hBEEF_0001, 1'b1, 1'b0);
    idle(2);
    checkVal("s4.state", 32'(dbgRxState), 32'd0);
    for (int i = 2; i < 10; i++) sendPkt(i, 11, 1'b0);
    idle(3);
    checkCodes("s4", 10, 1, 2'd3);
    checkCounts("s4", 54, 3, 1);

    // Strobe after 10 of 16 packets -> incomplete-session pulse
    strobe();
    idle(2);
    checkCodes("s5.strobe", 1, 0, 2'd3);
    checkVal("s5.errorCount", 32'(errorCount), 32'd4);
    sendPkt(0, 12, 1'b0);
    idle(3);
    checkCodes("s5.pkt0", 1, -1, 2'd0);
    checkCounts("s5", 55, 4, 1);

    // Channel drops mid-packet -> no verdict, then exempt session with gaps
    sendWord(hdrWord(1), 1'b0, 1'b0);
    sendWord(32'hCAFE_0001, 1'b0, 1'b0);
    sendWord(32'hBEEF_0001, 1'b0, 1'b0);
    chanUp = 1'b0;
    sendWord(sumWord(1, 12), 1'b1, 1'b0);
    idle(3);
    checkVal("ch.state", 32'(dbgRxState), 32'd0);
    checkVal("ch.noVerdict", 32'(codeQ.size()), 32'd0);
    chanUp = 1'b1;
    idle(2);
    strobe();
    for (int i = 0; i < 16; i++) sendPkt(i, 500, 1'b1);
    idle(3);
    checkCodes("s6", 16, -1, 2'd0);
    checkCounts("s6", 71, 4, 2);

    // Packet after the session is complete -> header error
    sendPkt(0, 500, 1'b0);
    idle(3);
    checkCodes("over", 1, 0, 2'd1);
    checkCounts("over", 71, 5, 2);

    // Counter clear
    @(negedge clk); clearCnt = 1'b1;
    @(negedge clk); clearCnt = 1'b0;
    checkCounts("clr", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
